data_mem_pipe: RTL and testbench
================================

Name: data_mem_pipe

Overview:
- Parametrised data memory for the pipelined processor's MEM stage.
- Single request port with a valid/ready handshake and a configurable fixed read latency; reads are fully pipelined, one per cycle.
- After every reset, a hardware clear sequence zeroes every word of the memory, not only the low addresses.
- The pipeline stalls on req_ready low; responses carry no backpressure.

Parameters:
DATA_W  16  word width in bits
ADDR_W  10  address width; depth = 2**ADDR_W words
RD_LAT  1   read latency in cycles, legal range 1..4; out-of-range values raise an elaboration-time $error

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  read data valid this cycle, single-cycle pulse per read
rsp_rdata  out  DATA_W  read data
init_busy  out  1  clear sequence in progress

Behaviour:
- Reset and output timing:
  - Reset is rst, synchronous, active-high; clock is clk.
  - All outputs are registered.
  - While rst is high: state = INIT, clr_cnt = 0, read pipeline flushed.
  - Outputs while rst is high: req_ready = 0, init_busy = 1, rsp_valid = 0, rsp_rdata = 0.
- State machine, two states:
  - INIT: each cycle, write 0 to mem[clr_cnt] and increment clr_cnt. When clr_cnt = 2**ADDR_W-1 is written, go to RUN.
  - INIT lasts exactly 2**ADDR_W cycles after rst deasserts. req_ready = 0 and init_busy = 1 throughout; requests are ignored, not queued.
  - RUN: req_ready = 1 and init_busy = 0. RUN leaves only via rst.
- Accept: a request is accepted on a rising edge where req_valid && req_ready.
- Write, accepted at edge N:
  - mem[req_addr] <= req_wdata at edge N.
  - No response is generated.
  - A read accepted at edge N+1 or later returns the new value.
- Read, accepted at edge N:
  - Data is sampled from mem[req_addr] as of edge N.
  - rsp_valid = 1 with rsp_rdata after edge N+RD_LAT, for exactly one cycle.
- Back-to-back reads on consecutive edges give consecutive rsp_valid pulses, in order, with no bubbles.
- rsp_rdata holds its last value when rsp_valid = 0. It is not cleared except by rst.
- The memory is single-port: at most one request per cycle, so there is no same-cycle read/write conflict.
- Reset mid-operation:
  - All in-flight reads are dropped; rsp_valid = 0 from the edge where rst is sampled.
  - The memory is fully re-cleared.
  - A write accepted on the same edge where rst is sampled high is discarded.
- Address wrap: clr_cnt wraps at 2**ADDR_W only at the INIT→RUN transition. Request addresses cannot exceed the depth because the address is exactly ADDR_W bits.

Optional Feature:
MEM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit computed over req_wdata.
  - Extra input err_inject (1 bit): when high on an accepted write, the stored parity bit is inverted.
  - Extra output rsp_perr (1 bit): asserted in the same cycle as rsp_valid when the recomputed parity of the stored data mismatches the stored bit. It is 0 when rsp_valid = 0 and during reset.
  - INIT writes correct parity for zero data, so parity is 0.
- Undefined: no parity storage, no err_inject or rsp_perr ports; behaviour otherwise identical.

Test Plan:
- Clear sequence (defaults): hold rst 3 cycles, release.
  - init_busy = 1 and req_ready = 0 for exactly 1024 cycles, then req_ready = 1.
  - Reads of addr 0x000, 0x1FF and 0x3FF all return 0x0000.
- Write/read (RD_LAT = 1): write 0xBEEF to 0x005, then read 0x005 on the next edge. rsp_valid is high exactly one cycle after the read accept, with rsp_rdata = 0xBEEF.
- Pipelining (RD_LAT = 3): write addr k ← k*3 for k = 0..7, then issue 8 back-to-back reads 0..7.
  - 8 consecutive rsp_valid pulses start 3 cycles after the first read accept.
  - Data is 0x0000, 0x0003, …, 0x0015 in order.
- Reset mid-flight (RD_LAT = 4): issue 2 reads, assert rst 2 cycles after the second accept.
  - No rsp_valid pulse appears.
  - After the clear sequence, the previously written addresses read 0x0000.
- Ignored during INIT: drive req_valid = 1, req_we = 1, addr 0x010, data 0x1234 throughout INIT. After RUN, a read of 0x010 returns 0x0000.
- Parity (MEM_PARITY_EN): write 0x00FF to 0x020 with err_inject = 1 and 0x00FF to 0x021 with err_inject = 0.
  - Read 0x020 → rsp_perr = 1.
  - Read 0x021 → rsp_perr = 0.

Source files
------------

// File: rtl/data_mem_pipe.sv
// data_mem_pipe: MEM-stage data memory with a valid/ready request port and a
// fixed, fully pipelined read latency (RD_LAT cycles).
// After every reset a clear sequence zeroes every word before requests are taken.
// Optional build macro: MEM_PARITY_EN adds a per-word even-parity bit, an
// err_inject input that corrupts the stored parity, and a rsp_perr output.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | clearing mem[clr_cnt] each cycle, requests ignored
// RUN   | normal operation, one request per cycle accepted
module data_mem_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef MEM_PARITY_EN
    input  logic              err_inject,
    output logic              rsp_perr,
`endif
    output logic              init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
            $error("data_mem_pipe: RD_LAT must be in 1..4");
        end
    endgenerate

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [WORD_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WORD_W-1:0]   wr_word;

    logic                pipe_vld  [RD_LAT];
    logic [WORD_W-1:0]   pipe_word [RD_LAT];

    // A request counts only while running and outside reset; a write that
    // coincides with rst is dropped here.
    assign accept = req_valid && req_ready && !rst;

    // Single write port shared by the clear sequence and accepted writes.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_cnt;
        wr_word = '0;
        if (!rst) begin
            if (state == ST_INIT) begin
                wr_en = 1'b1;
            end else if (accept && req_we) begin
                wr_en   = 1'b1;
                wr_addr = req_addr;
`ifdef MEM_PARITY_EN
                wr_word = {(^req_wdata) ^ err_inject, req_wdata};
`else
                wr_word = req_wdata;
`endif
            end
        end
    end

    // Sequencer: clear every word once, then hand the port to the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            clr_cnt   <= '0;
            req_ready <= 1'b0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state     <= ST_RUN;
                        req_ready <= 1'b1;
                        init_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory array, left without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    // Read pipeline: stage 0 samples the array on the accept edge, later
    // stages add latency; data registers carry no reset since only the valid
    // bit qualifies them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
            end
        end else begin
            pipe_vld[0] <= accept && !req_we;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
        pipe_word[0] <= mem[req_addr];
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_word[i] <= pipe_word[i-1];
        end
    end

    // Response register: pulse valid, hold data between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef MEM_PARITY_EN
            rsp_perr  <= 1'b0;
`endif
        end else begin
            rsp_valid <= pipe_vld[RD_LAT-1];
            if (pipe_vld[RD_LAT-1]) begin
                rsp_rdata <= pipe_word[RD_LAT-1][DATA_W-1:0];
            end
`ifdef MEM_PARITY_EN
            // Odd population over data plus stored bit means a mismatch.
            rsp_perr <= pipe_vld[RD_LAT-1] && (^pipe_word[RD_LAT-1]);
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Testbench for data_mem_pipe: two instances (RD_LAT = 1 and RD_LAT = 4)
// share one stimulus stream. Expected responses, tagged with the cycle they
// must appear in, are queued per instance; a negedge monitor pops and checks.
module tb_data_mem_pipe;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam int LAT0   = 1;
    localparam int LAT1   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst        = 1'b1;
    logic              req_valid  = 1'b0;
    logic              req_we     = 1'b0;
    logic [ADDR_W-1:0] req_addr   = '0;
    logic [DATA_W-1:0] req_wdata  = '0;
    logic              err_inject = 1'b0;

    logic [1:0]              req_ready;
    logic [1:0]              rsp_valid;
    logic [1:0]              init_busy;
    logic [1:0][DATA_W-1:0]  rsp_rdata;
`ifdef MEM_PARITY_EN
    logic [1:0]              rsp_perr;
`endif

    data_mem_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(LAT0)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
`ifdef MEM_PARITY_EN
        .err_inject(err_inject), .rsp_perr(rsp_perr[0]),
`endif
        .init_busy(init_busy[0])
    );

    data_mem_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(LAT1)) u_lat4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
`ifdef MEM_PARITY_EN
        .err_inject(err_inject), .rsp_perr(rsp_perr[1]),
`endif
        .init_busy(init_busy[1])
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
        logic              perr;
    } exp_t;

    exp_t              q [2][$];
    logic [DATA_W-1:0] ref_mem  [DEPTH];
    logic              ref_pbad [DEPTH];
    logic [DATA_W-1:0] last_rd  [2];
    int                cyc    = 0;
    logic              rst_q  = 1'b1;
    bit                run    = 1'b0;
    int                errors = 0;
    int                checks = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d: got %h, expected %h", name, d, cyc, act, req);
        end
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst_q) begin
                chk("rst_outputs", d, {13'b0, rsp_valid[d], req_ready[d], init_busy[d], rsp_rdata[d]},
                    {13'b0, 1'b0, 1'b0, 1'b1, 16'h0000});
                last_rd[d] = '0;
            end else begin
                while (q[d].size() > 0 && q[d][0].cyc < cyc) begin
                    e = q[d].pop_front();
                    checks++;
                    errors++;
                    $display("FAIL rsp_missing dut%0d cyc=%0d: no rsp_valid, expected data %h at cyc %0d",
                             d, cyc, e.data, e.cyc);
                end
                if (rsp_valid[d]) begin
                    if (q[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected dut%0d cyc=%0d: got rsp_valid=1 data %h, expected rsp_valid=0",
                                 d, cyc, rsp_rdata[d]);
                    end else begin
                        e = q[d].pop_front();
                        chk("rsp_cycle", d, cyc, e.cyc);
                        chk("rsp_data", d, {16'h0, rsp_rdata[d]}, {16'h0, e.data});
`ifdef MEM_PARITY_EN
                        chk("rsp_perr", d, {31'b0, rsp_perr[d]}, {31'b0, e.perr});
`endif
                        last_rd[d] = e.data;
                    end
                end else begin
                    chk("rdata_hold", d, {16'h0, rsp_rdata[d]}, {16'h0, last_rd[d]});
`ifdef MEM_PARITY_EN
                    chk("perr_idle", d, {31'b0, rsp_perr[d]}, 32'h0);
`endif
                end
            end
        end
    end

    // One request slot: drive just after the edge, so the next edge accepts it.
    task automatic drive(input bit v, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] dat, input bit ei);
        exp_t e;
        @(posedge clk);
        #1;
        req_valid  = v;
        req_we     = we;
        req_addr   = a;
        req_wdata  = dat;
        err_inject = ei;
        if (run && v) begin
            if (we) begin
                ref_mem[a]  = dat;
                ref_pbad[a] = err_inject;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    e.data = ref_mem[a];
                    e.perr = ref_pbad[a];
                    e.cyc  = cyc + 1 + lat_of(d);
                    q[d].push_back(e);
                end
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Reset for 'hold' edges, then verify the clear window length. Inputs
    // are left as the caller set them so INIT-time requests can be probed.
    task automatic do_reset(input int hold);
        int bad;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run = 1'b0;
        for (int d = 0; d < 2; d++) begin
            while (q[d].size() > 0 && q[d][q[d].size()-1].cyc > cyc) begin
                void'(q[d].pop_back());
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]  = '0;
            ref_pbad[i] = 1'b0;
        end
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (req_ready !== 2'b00 || init_busy !== 2'b11) bad++;
        end
        chk("init_window_cycles_bad", 0, bad, 0);
        @(negedge clk);
        chk("run_after_init", 0, {30'b0, req_ready}, 32'h3);
        chk("busy_after_init", 0, {30'b0, init_busy}, 32'h0);
        req_valid = 1'b0;
        req_we    = 1'b0;
        run       = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // A write held on the port throughout INIT must not land.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 10'h010;
        req_wdata = 16'h1234;
        do_reset(3);

        drive(1, 0, 10'h000, '0, 0);
        drive(1, 0, 10'h1FF, '0, 0);
        drive(1, 0, 10'h3FF, '0, 0);
        drive(1, 0, 10'h010, '0, 0);

        drive(1, 1, 10'h005, 16'hBEEF, 0);
        drive(1, 0, 10'h005, '0, 0);
        idle();

        for (int k = 0; k < 8; k++) drive(1, 1, 10'(k), 16'(k * 3), 0);
        for (int k = 0; k < 8; k++) drive(1, 0, 10'(k), '0, 0);
        repeat (6) idle();

        drive(1, 1, 10'h020, 16'h00FF, 1);
        drive(1, 1, 10'h021, 16'h00FF, 0);
        drive(1, 0, 10'h020, '0, 0);
        drive(1, 0, 10'h021, '0, 0);

        for (int n = 0; n < 400; n++) begin
            logic [ADDR_W-1:0] a;
            a = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, 16'($urandom),
                  $urandom_range(0, 3) == 0);
        end
        repeat (6) idle();

        // Reset with two reads in flight: rst sampled two edges after the
        // second accept, which drops both RD_LAT=4 responses.
        drive(1, 1, 10'h040, 16'hAAAA, 0);
        drive(1, 1, 10'h041, 16'h5555, 0);
        drive(1, 0, 10'h040, '0, 0);
        drive(1, 0, 10'h041, '0, 0);
        idle();
        do_reset(2);

        drive(1, 0, 10'h040, '0, 0);
        drive(1, 0, 10'h041, '0, 0);
        drive(1, 0, 10'h005, '0, 0);
        drive(1, 0, 10'h007, '0, 0);
        repeat (8) idle();

        for (int d = 0; d < 2; d++) chk("queue_drained", d, q[d].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
